// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, derived widths and address helper for icache_dm
//
// Purpose: refill state enum, width functions derived from the cache
// geometry, and a helper that builds a line base address from tag and index.
// Ports: none (package).

package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int calc_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int words_per_line);
        return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
    endfunction

    // Byte address of word 0 of the line {tag, index}; caller truncates to its width.
    function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] idx,
                                              input int idx_w, input int off_w);
        return (tag << (idx_w + off_w + 2)) | (idx << (off_w + 2));
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - instruction memory read bus between icache_dm and memory
//
// Purpose: req/ack read handshake. Master (cache) holds mem_req/mem_addr
// stable until mem_ack; slave returns mem_rdata in the ack cycle.
// Signals: mem_req, mem_addr[ADDR_W], mem_rdata[32], mem_ack.

interface icache_dm_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/icache_refill_fsm.sv
// rtl/icache_refill_fsm.sv - line refill sequencer for icache_dm
//
// Purpose: on start_i latches the missing tag/index, walks the line word by
// word over the memory bus and raises write enables for the cache arrays.
// Ports: clk, reset (sync, active-high), start_i, flush_i, tag_i, idx_i,
//        busy_o, data_we_o, wr_off_o, fill_done_o, miss_tag_o, miss_idx_o,
//        mem (icache_dm_if master).

module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32,
    localparam int OFF_W = calc_off_w(WORDS_PER_LINE),
    localparam int IDX_W = calc_idx_w(LINES),
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             busy_o,
    output logic             data_we_o,
    output logic [OFF_W-1:0] wr_off_o,
    output logic             fill_done_o,
    output logic [TAG_W-1:0] miss_tag_o,
    output logic [IDX_W-1:0] miss_idx_o,
    icache_dm_if.master      mem
);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        data_we_o   = 1'b0;
        fill_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = REFILL;
                    miss_tag_d = tag_i;
                    miss_idx_d = idx_i;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = ADDR_W'(line_addr(64'(tag_i), 64'(idx_i), IDX_W, OFF_W));
                end
            end
            REFILL: begin
                // Flush beats a coincident final ack so the partial line is never validated.
                if (flush_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (mem_req_q && mem.mem_ack) begin
                    data_we_o = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        fill_done_o = 1'b1;
                        mem_req_d   = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(4);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o       = (state_q == REFILL);
    assign wr_off_o     = cnt_q;
    assign miss_tag_o   = miss_tag_q;
    assign miss_idx_o   = miss_idx_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with zero-latency lookup
//
// Purpose: combinational tag lookup in front of the IF/ID register; misses
// refill a whole line through icache_refill_fsm. Optional macro
// ICACHE_STATS_EN adds hit_count/miss_count outputs.
// Ports: clk, reset (sync, active-high), fetch_en, pc, flush,
//        instruction_out, hit, busy, [hit_count, miss_count], mem (bus master).

module icache_dm
    import icache_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       instruction_out,
    output logic              hit,
    output logic              busy,
`ifdef ICACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    icache_dm_if.master       mem
);

    localparam int OFF_W = calc_off_w(WORDS_PER_LINE);
    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES, WORDS_PER_LINE);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             unused_pc_byte;
    logic             start;
    logic             data_we;
    logic             fill_done;
    logic [OFF_W-1:0] wr_off;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;

    assign pc_off         = pc[OFF_W+1 -: OFF_W];
    assign pc_idx         = pc[IDX_W+OFF_W+1 -: IDX_W];
    assign pc_tag         = pc[ADDR_W-1 -: TAG_W];
    assign unused_pc_byte = ^pc[1:0];

    // Lookup only while idle; a flush cycle never reports a hit.
    assign hit             = fetch_en & ~busy & ~flush & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
    assign instruction_out = data_q[pc_idx][pc_off];
    assign start           = fetch_en & ~busy & ~flush & ~hit;

    icache_refill_fsm #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_W         (ADDR_W)
    ) u_refill (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .flush_i     (flush),
        .tag_i       (pc_tag),
        .idx_i       (pc_idx),
        .busy_o      (busy),
        .data_we_o   (data_we),
        .wr_off_o    (wr_off),
        .fill_done_o (fill_done),
        .miss_tag_o  (miss_tag),
        .miss_idx_o  (miss_idx),
        .mem         (mem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill_done) begin
            valid_q[miss_idx] <= 1'b1;
        end
    end

    // Data and tag storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[miss_idx][wr_off] <= mem.mem_rdata;
        end
        if (fill_done) begin
            tag_q[miss_idx] <= miss_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (start) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - self-checking bench for icache_dm against a line-level reference model

module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instruction_out;
    logic        hit;
    logic        busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    icache_dm_if #(.ADDR_W(32)) bus ();

    icache_dm #(
        .LINES          (16),
        .WORDS_PER_LINE (4),
        .ADDR_W         (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .pc              (pc),
        .flush           (flush),
        .instruction_out (instruction_out),
        .hit             (hit),
        .busy            (busy),
`ifdef ICACHE_STATS_EN
        .hit_count       (hit_count),
        .miss_count      (miss_count),
`endif
        .mem             (bus)
    );

    // Read-only instruction memory: word at byte address a is (a>>2)+0x90,
    // so 0x40..0x4C hold 0xA0..0xA3.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h90;
    endfunction

    assign bus.mem_rdata = mem_word(bus.mem_addr);

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: which lines are resident, plus the one outstanding line fill.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    bit          m_refill;
    logic [31:0] m_base;
    int          m_cnt;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic        o_hit;
    logic        o_req;
    logic [31:0] o_instr;
    logic [31:0] o_addr;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_refill = 1'b0;
        m_cnt    = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic step(input logic fe, input logic [31:0] p, input logic fl,
                        input logic ack, input logic rst);
        int   idx;
        int   bidx;
        logic exp_hit;
        @(negedge clk);
        fetch_en    = fe;
        pc          = p;
        flush       = fl;
        bus.mem_ack = ack;
        reset       = rst;
        #1;
        idx     = int'(p[7:4]);
        exp_hit = fe && !m_refill && !fl && m_valid[idx] && (m_tag[idx] == p[31:8]);
        o_hit   = hit;
        o_req   = bus.mem_req;
        o_instr = instruction_out;
        o_addr  = bus.mem_addr;
        check_eq("hit", 32'(hit), 32'(exp_hit));
        check_eq("busy", 32'(busy), 32'(m_refill));
        check_eq("mem_req", 32'(bus.mem_req), 32'(m_refill));
        if (m_refill) check_eq("mem_addr", bus.mem_addr, m_base + 32'(4 * m_cnt));
        if (exp_hit) check_eq("instr", instruction_out, mem_word({p[31:2], 2'b00}));
`ifdef ICACHE_STATS_EN
        check_eq("hit_count", hit_count, m_hits);
        check_eq("miss_count", miss_count, m_misses);
`endif
        if (rst) begin
            model_reset();
        end else begin
            if (exp_hit) m_hits++;
            if (fl) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                m_refill = 1'b0;
            end else if (m_refill) begin
                if (ack) begin
                    m_cnt++;
                    if (m_cnt == 4) begin
                        bidx          = int'(m_base[7:4]);
                        m_valid[bidx] = 1'b1;
                        m_tag[bidx]   = m_base[31:8];
                        m_refill      = 1'b0;
                    end
                end
            end else if (fe && !exp_hit) begin
                m_refill = 1'b1;
                m_base   = {p[31:4], 4'b0000};
                m_cnt    = 0;
                m_misses++;
            end
        end
    endtask

    task automatic fill_line(input logic [31:0] p);
        step(1'b1, p, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++) step(1'b1, p, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tg;
        case ($urandom_range(0, 3))
            0:       tg = 32'h0;
            1:       tg = 32'h1;
            2:       tg = 32'h2;
            default: tg = 32'h80_0001;
        endcase
        return (tg << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
    endfunction

    initial begin
        reset       = 1'b1;
        fetch_en    = 1'b0;
        pc          = '0;
        flush       = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mem_addr", o_addr, 32'h0);
        check_eq("rst_mem_req", 32'(o_req), 32'h0);

        // Basic fill of 0x40
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        check_eq("s1_first_miss", 32'(o_hit), 32'h0);
        for (int w = 0; w < 4; w++) begin
            step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
            check_eq("s1_req", 32'(o_req), 32'h1);
            check_eq("s1_addr", o_addr, 32'h40 + 32'(4 * w));
        end
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        check_eq("s1_hit", 32'(o_hit), 32'h1);
        check_eq("s1_instr_a0", o_instr, 32'hA0);
        step(1'b1, 32'h48, 1'b0, 1'b0, 1'b0);
        check_eq("s1_instr_a2", o_instr, 32'hA2);
        check_eq("s1_no_req", 32'(o_req), 32'h0);

`ifdef ICACHE_STATS_EN
        repeat (3) step(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("stats_hits5", hit_count, 32'd5);
        check_eq("stats_miss1", miss_count, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("stats_rst_hits", hit_count, 32'd0);
        check_eq("stats_rst_miss", miss_count, 32'd0);
        fill_line(32'h40);
`endif

        // Conflict on index 4
        fill_line(32'h140);
        step(1'b1, 32'h144, 1'b0, 1'b0, 1'b0);
        check_eq("conf_hit_140", 32'(o_hit), 32'h1);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        check_eq("conf_evicted", 32'(o_hit), 32'h0);
        for (int w = 0; w < 4; w++) step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);

        // Backpressure on word 1 of 0x80
        step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
            check_eq("bp_req", 32'(o_req), 32'h1);
            check_eq("bp_addr", o_addr, 32'h84);
        end
        for (int w = 0; w < 3; w++) step(1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h8C, 1'b0, 1'b0, 1'b0);
        check_eq("bp_line_hit", 32'(o_hit), 32'h1);
        check_eq("bp_line_word3", o_instr, mem_word(32'h8C));

        // Flush after two acks
        step(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hC0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
        check_eq("fl_req_dropped", 32'(o_req), 32'h0);
        check_eq("fl_miss", 32'(o_hit), 32'h0);
        step(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0);
        check_eq("fl_restart_addr", o_addr, 32'hC0);
        for (int w = 0; w < 3; w++) step(1'b1, 32'hC0, 1'b0, 1'b1, 1'b0);

        // Flush coincident with the final ack
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        check_eq("fl_last_ack_miss", 32'(o_hit), 32'h0);
        for (int w = 0; w < 4; w++) step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);

        // Reset mid-refill
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid_req", 32'(o_req), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 7) != 0, rand_pc(), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
